// File: rtl/dut_result_checker_if.sv
// Result-checker bus: run control, result-pair handshake and run status.
// The master drives stimulus pairs, the slave (checker) reports status.
interface dut_result_checker_if;
  logic        start;
  logic [15:0] num_vec;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] ref_res;
  logic [79:0] opt_res;
  logic        done;
  logic        pass;
  logic [15:0] mismatch_cnt;
  logic [15:0] first_fail_idx;
  logic [79:0] first_fail_diff;
  logic [31:0] signature;

  modport master (
    output start, num_vec, in_valid,
    output ref_res, opt_res,
    input  in_ready, done, pass,
    input  mismatch_cnt, first_fail_idx,
    input  first_fail_diff, signature
  );

  modport slave (
    input  start, num_vec, in_valid,
    input  ref_res, opt_res,
    output in_ready, done, pass,
    output mismatch_cnt, first_fail_idx,
    output first_fail_diff, signature
  );
endinterface

// File: rtl/dut_result_checker.sv
// Compares reference vs optimized netlist results per vector,
// counts mismatches, latches the first failure and compacts opt_res in a MISR.
module dut_result_checker (
  input logic            clk,
  input logic            rst,
  dut_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_vec_idx;
  logic [15:0] r_num_vec;
  logic [15:0] r_mm_cnt;
  logic [15:0] r_ff_idx;
  logic [79:0] r_ff_diff;
  logic [31:0] r_sig;

  logic        w_start_ok;
  logic        w_xfer;
  logic        w_last;
  logic        w_mis;
  logic        w_fb;
  logic [31:0] w_fold;
  logic [31:0] w_sig_nxt;

  assign w_start_ok = bus.start && (r_state != S_RUN);
  assign w_xfer     = bus.in_valid && (r_state == S_RUN);
  assign w_last     = w_xfer && (r_vec_idx == r_num_vec - 16'd1);
  assign w_mis      = (bus.ref_res != bus.opt_res);

  assign w_fb      = r_sig[31] ^ r_sig[21] ^ r_sig[1] ^ r_sig[0];
  assign w_fold    = bus.opt_res[31:0] ^ bus.opt_res[63:32]
                   ^ {16'h0, bus.opt_res[79:64]};
  assign w_sig_nxt = {r_sig[30:0], w_fb} ^ w_fold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next = (bus.num_vec == 16'd0) ? S_DONE : S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    bus.pass     = 1'b0;
    unique case (r_state)
      S_RUN:  bus.in_ready = 1'b1;
      S_DONE: begin
        bus.done = 1'b1;
        bus.pass = (r_mm_cnt == 16'd0);
      end
      default: ;
    endcase
  end

  // A zero count doubles as "no failure seen yet" since it saturates, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec_idx <= '0;
      r_num_vec <= '0;
      r_mm_cnt  <= '0;
      r_ff_idx  <= '0;
      r_ff_diff <= '0;
      r_sig     <= 32'hFFFF_FFFF;
    end else if (w_start_ok) begin
      r_vec_idx <= '0;
      r_num_vec <= bus.num_vec;
      r_mm_cnt  <= '0;
      r_ff_idx  <= '0;
      r_ff_diff <= '0;
      r_sig     <= 32'hFFFF_FFFF;
    end else if (w_xfer) begin
      r_vec_idx <= r_vec_idx + 16'd1;
      r_sig     <= w_sig_nxt;
      if (w_mis) begin
        if (r_mm_cnt != 16'hFFFF) r_mm_cnt <= r_mm_cnt + 16'd1;
        if (r_mm_cnt == 16'd0) begin
          r_ff_idx  <= r_vec_idx;
          r_ff_diff <= bus.ref_res ^ bus.opt_res;
        end
      end
    end
  end

  assign bus.mismatch_cnt    = r_mm_cnt;
  assign bus.first_fail_idx  = r_ff_idx;
  assign bus.first_fail_diff = r_ff_diff;
  assign bus.signature       = r_sig;

endmodule

// File: tb/tb_dut_result_checker.sv
// Self-checking bench for dut_result_checker: vector table,
// scoreboard of per-transfer status and hand-written corner sequences.
module tb_dut_result_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dut_result_checker_if bus ();

  dut_result_checker u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] ffi;
    logic [79:0] ffd;
    logic [31:0] sig;
  } exp_t;

  typedef struct {
    logic [79:0] r;
    logic [79:0] o;
    logic [15:0] cnt;
    logic [15:0] ffi;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_idx, m_n, m_cnt, m_ffi;
  logic [79:0] m_ffd;
  logic [31:0] m_sig;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] s,
                                           input logic [79:0] o);
    logic [31:0] f;
    logic        b;
    f = o[31:0] ^ o[63:32] ^ {16'h0, o[79:64]};
    b = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], b} ^ f;
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},  80'(bus.in_ready), 80'd0);
    chk({tag, "_done"}, 80'(bus.done), 80'd0);
    chk({tag, "_pass"}, 80'(bus.pass), 80'd0);
    chk({tag, "_cnt"},  80'(bus.mismatch_cnt), 80'd0);
    chk({tag, "_ffi"},  80'(bus.first_fail_idx), 80'd0);
    chk({tag, "_ffd"},  bus.first_fail_diff, 80'd0);
    chk({tag, "_sig"},  80'(bus.signature), 80'hFFFF_FFFF);
  endtask

  // st: 1 = RUN, 2 = DONE
  task automatic chk_status(input string tag, input int st);
    chk({tag, "_rdy"},  80'(bus.in_ready), 80'(st == 1));
    chk({tag, "_done"}, 80'(bus.done), 80'(st == 2));
    chk({tag, "_pass"}, 80'(bus.pass), 80'(st == 2 && m_cnt == 0));
    chk({tag, "_cnt"},  80'(bus.mismatch_cnt), 80'(m_cnt));
    chk({tag, "_ffi"},  80'(bus.first_fail_idx), 80'(m_ffi));
    chk({tag, "_ffd"},  bus.first_fail_diff, m_ffd);
    chk({tag, "_sig"},  80'(bus.signature), 80'(m_sig));
  endtask

  task automatic do_start(input logic [15:0] n);
    bus.num_vec = n;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_idx = 0; m_n = n; m_cnt = 0;
    m_ffi = 0; m_ffd = 0; m_sig = 32'hFFFF_FFFF;
    chk_status("start", (n == 0) ? 2 : 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      bus.ref_res = rnd80();
      bus.opt_res = rnd80();
      @(posedge clk); #1;
    end
  endtask

  task automatic xfer(input logic [79:0] r, input logic [79:0] o);
    exp_t e;
    bit   last;
    chk("rdy_pre", 80'(bus.in_ready), 80'd1);
    bus.ref_res  = r;
    bus.opt_res  = o;
    bus.in_valid = 1'b1;
    if (r != o) begin
      if (m_cnt == 0) begin
        m_ffi = m_idx;
        m_ffd = r ^ o;
      end
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    m_sig = sig_step(m_sig, o);
    m_idx++;
    last = (m_idx == m_n);
    e = '{m_cnt, m_ffi, m_ffd, m_sig};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    chk("sb_cnt", 80'(bus.mismatch_cnt), 80'(e.cnt));
    chk("sb_ffi", 80'(bus.first_fail_idx), 80'(e.ffi));
    chk("sb_ffd", bus.first_fail_diff, e.ffd);
    chk("sb_sig", 80'(bus.signature), 80'(e.sig));
    chk("sb_rdy", 80'(bus.in_ready), 80'(!last));
    chk("sb_done", 80'(bus.done), 80'(last));
  endtask

  initial begin
    logic [79:0] r;
    bus.start = 0; bus.num_vec = 0; bus.in_valid = 0;
    bus.ref_res = 0; bus.opt_res = 0;
    m_idx = 0; m_n = 0; m_cnt = 0; m_ffi = 0;
    m_ffd = 0; m_sig = 32'hFFFF_FFFF;

    tbl[0] = '{80'h1234_5678_9ABC_DEF0_1357, 80'h1234_5678_9ABC_DEF0_1357, 16'd0, 16'd0};
    tbl[1] = '{80'hFFFF_0000_FFFF_0000_A5A5, 80'hFFFF_0000_FFFF_0000_A5A5, 16'd0, 16'd0};
    tbl[2] = '{80'h0F0F_0F0F_0F0F_0F0F_0F0F, 80'h8F0F_0F0F_0F0F_0F0F_0F0F, 16'd1, 16'd2};
    tbl[3] = '{80'hDEAD_BEEF_CAFE_F00D_0001, 80'hDEAD_BEEF_CAFE_F00D_0001, 16'd1, 16'd2};
    tbl[4] = '{80'h0000_0000_0000_0000_00FF, 80'h0000_0000_0000_0000_000F, 16'd2, 16'd2};

    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("rst");
    bus.in_valid = 1'b1;
    bus.ref_res = 80'h5; bus.opt_res = 80'h6;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk_reset("idle_vld");

    do_start(4);
    for (int i = 0; i < 4; i++) xfer(80'h1, 80'h1);
    chk("s4_done", 80'(bus.done), 80'd1);
    chk("s4_pass", 80'(bus.pass), 80'd1);
    chk("s4_sig", 80'(bus.signature), 80'hFFFF_FFFF);
    idle(3);
    chk_status("s4_hold", 2);

    do_start(5);
    for (int i = 0; i < 5; i++) begin
      xfer(tbl[i].r, tbl[i].o);
      chk("tbl_cnt", 80'(bus.mismatch_cnt), 80'(tbl[i].cnt));
      chk("tbl_ffi", 80'(bus.first_fail_idx), 80'(tbl[i].ffi));
    end
    chk("s5_ffd", bus.first_fail_diff, 80'h8000_0000_0000_0000_0000);
    chk("s5_pass", 80'(bus.pass), 80'd0);
    chk("s5_done", 80'(bus.done), 80'd1);

    do_start(0);
    idle(2);
    chk_status("s0_hold", 2);

    do_start(3);
    xfer(rnd80(), rnd80());
    idle(2);
    chk_status("gap", 1);
    bus.start = 1'b1; bus.num_vec = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk_status("ign_start", 1);
    r = rnd80();
    xfer(r, r);
    xfer(rnd80(), rnd80());
    bus.in_valid = 1'b1;
    bus.ref_res = 80'h1; bus.opt_res = 80'h2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_status("done_vld", 2);

    do_start(6);
    xfer(80'h3, 80'h7);
    xfer(rnd80(), rnd80());
    #3 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(posedge clk); #1 rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.ref_res = 80'h9; bus.opt_res = 80'hA;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(1);
    chk_reset("post_rst");
    do_start(1);
    xfer(80'hABCD, 80'hABCC);
    chk("s1_cnt", 80'(bus.mismatch_cnt), 80'd1);
    chk("s1_ffi", 80'(bus.first_fail_idx), 80'd0);
    chk("s1_done", 80'(bus.done), 80'd1);
    chk("s1_pass", 80'(bus.pass), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
